// File: rtl/sr_drive_pkg.sv
// Shared definitions for the SR latch pulse driver.
//   state_e      : FSM state encoding (IDLE, PULSE_S, PULSE_R, GAP)
//   DEF_*        : default parameter values used by the top and the debouncer
package sr_drive_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PULSE_S = 2'd1,
    PULSE_R = 2'd2,
    GAP     = 2'd3
  } state_e;

  localparam int unsigned DEF_DB_CYCLES    = 4;
  localparam int unsigned DEF_PULSE_CYCLES = 2;
  localparam int unsigned DEF_CNT_W        = 8;
  localparam bit          DEF_R_PRIORITY   = 1'b1;

endpackage

// File: rtl/sr_debounce.sv
// One input channel: 2-flop synchroniser, debounce filter and rising-edge detect.
// Ports:
//   Clk     in  system clock, rising edge
//   ResetN  in  asynchronous active-low reset
//   raw_i   in  raw asynchronous, possibly bouncy level
//   rise_o  out registered one-cycle pulse on each accepted 0->1 change of the filtered level
module sr_debounce
  import sr_drive_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DEF_DB_CYCLES,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic Clk,
  input  logic ResetN,
  input  logic raw_i,
  output logic rise_o
);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic             rise_q;
  logic             rise_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Debounce: count consecutive cycles the synced level disagrees with the accepted one.
  always_comb begin
    cnt_d    = {CNT_W{1'b0}};
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == DB_LAST) begin
        // DB_CYCLES-th consecutive disagreeing edge: accept the new level
        stable_d = ~stable_q;
        cnt_d    = {CNT_W{1'b0}};
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = {CNT_W{1'b0}};
    end
    rise_d = stable_d & ~stable_q;
  end

  // Synchroniser, debounce state and registered rise pulse.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      rise_q   <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/sr_pulse_driver.sv
// Turns raw set/reset requests into clean, mutually exclusive S/R pulses for an SR latch
// and tracks the latch state expected downstream.
// Ports:
//   Clk      in  system clock, rising edge
//   ResetN   in  asynchronous active-low reset
//   S_in     in  raw set request (asynchronous, may bounce)
//   R_in     in  raw reset request (asynchronous, may bounce)
//   S        out registered set pulse, PULSE_CYCLES wide
//   R        out registered reset pulse, PULSE_CYCLES wide
//   Busy     out FSM not in IDLE
//   Conflict out one-cycle flag: set and reset both wanted in the same IDLE cycle
//   Qmodel   out expected latch Q
module sr_pulse_driver
  import sr_drive_pkg::*;
#(
  parameter int unsigned DB_CYCLES    = DEF_DB_CYCLES,
  parameter int unsigned PULSE_CYCLES = DEF_PULSE_CYCLES,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter bit          R_PRIORITY   = DEF_R_PRIORITY
) (
  input  logic Clk,
  input  logic ResetN,
  input  logic S_in,
  input  logic R_in,
  output logic S,
  output logic R,
  output logic Busy,
  output logic Conflict,
  output logic Qmodel
);

  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic             req_s;
  logic             req_r;
  logic             s_go;
  logic             r_go;
  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] pcnt_q;
  logic [CNT_W-1:0] pcnt_d;
  logic             pend_s_q;
  logic             pend_s_d;
  logic             pend_r_q;
  logic             pend_r_d;
  logic             s_q;
  logic             s_d;
  logic             r_q;
  logic             r_d;
  logic             busy_q;
  logic             busy_d;
  logic             conflict_q;
  logic             conflict_d;
  logic             qmodel_q;
  logic             qmodel_d;

  sr_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_s (
    .Clk    (Clk),
    .ResetN (ResetN),
    .raw_i  (S_in),
    .rise_o (req_s)
  );

  sr_debounce #(.DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_db_r (
    .Clk    (Clk),
    .ResetN (ResetN),
    .raw_i  (R_in),
    .rise_o (req_r)
  );

  // Next-state, pending-request, pulse-counter and output decode.
  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    pend_s_d   = pend_s_q;
    pend_r_d   = pend_r_q;
    conflict_d = 1'b0;
    qmodel_d   = qmodel_q;
    s_go       = req_s | pend_s_q;
    r_go       = req_r | pend_r_q;
    case (state_q)
      IDLE: begin
        pcnt_d   = {CNT_W{1'b0}};
        // Whatever is granted here is consumed; the loser of a conflict is dropped.
        pend_s_d = 1'b0;
        pend_r_d = 1'b0;
        if (s_go && r_go) begin
          conflict_d = 1'b1;
          if (R_PRIORITY) begin
            state_d  = PULSE_R;
            qmodel_d = 1'b0;
          end else begin
            state_d  = PULSE_S;
            qmodel_d = 1'b1;
          end
        end else if (s_go) begin
          state_d  = PULSE_S;
          qmodel_d = 1'b1;
        end else if (r_go) begin
          state_d  = PULSE_R;
          qmodel_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      PULSE_S, PULSE_R: begin
        pend_s_d = pend_s_q | req_s;
        pend_r_d = pend_r_q | req_r;
        if (pcnt_q == PULSE_LAST) begin
          state_d = GAP;
          pcnt_d  = {CNT_W{1'b0}};
        end else begin
          pcnt_d = pcnt_q + CNT_ONE;
        end
      end
      GAP: begin
        pend_s_d = pend_s_q | req_s;
        pend_r_d = pend_r_q | req_r;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Outputs are registered copies of the next state, so they follow state_q exactly.
    s_d    = (state_d == PULSE_S);
    r_d    = (state_d == PULSE_R);
    busy_d = (state_d != IDLE);
  end

  // State, counters, pending flags and registered outputs.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q    <= IDLE;
      pcnt_q     <= {CNT_W{1'b0}};
      pend_s_q   <= 1'b0;
      pend_r_q   <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
      qmodel_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      pend_s_q   <= pend_s_d;
      pend_r_q   <= pend_r_d;
      s_q        <= s_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
      qmodel_q   <= qmodel_d;
    end
  end

  assign S        = s_q;
  assign R        = r_q;
  assign Busy     = busy_q;
  assign Conflict = conflict_q;
  assign Qmodel   = qmodel_q;

endmodule

// File: tb/tb_sr_pulse_driver.sv
// Self-checking bench for sr_pulse_driver (DB_CYCLES=4, PULSE_CYCLES=2, R_PRIORITY=1).
module tb_sr_pulse_driver;

  localparam int DB = 4;
  localparam int PW = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic s_in;
  logic r_in;
  logic s_o, r_o, busy_o, conf_o, q_o;

  int checks = 0;
  int errors = 0;

  sr_pulse_driver #(.DB_CYCLES(DB), .PULSE_CYCLES(PW), .CNT_W(8), .R_PRIORITY(1'b1)) dut (
    .Clk      (clk),
    .ResetN   (rst_n),
    .S_in     (s_in),
    .R_in     (r_in),
    .S        (s_o),
    .R        (r_o),
    .Busy     (busy_o),
    .Conflict (conf_o),
    .Qmodel   (q_o)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (timeline based) ----------------
  logic raw_h [0:1][0:4095];   // raw input seen at each edge since reset
  int   m_k;                   // edges since reset
  logic m_stable [0:1];
  logic m_req    [0:1];        // accepted rise, acted upon at the next edge
  logic m_pend   [0:1];
  int   m_kind;                // 0 none, 1 set pulse, 2 reset pulse
  int   m_start;               // edge at which the current pulse began
  logic m_conf, m_q;
  logic e_s, e_r, e_busy;

  function automatic logic hist(input int ch, input int idx);
    if (idx < 0) return 1'b0;
    return raw_h[ch][idx];
  endfunction

  task automatic model_reset();
    m_k = 0;
    for (int c = 0; c < 2; c++) begin
      m_stable[c] = 1'b0; m_req[c] = 1'b0; m_pend[c] = 1'b0;
    end
    m_kind = 0; m_start = 0; m_conf = 1'b0; m_q = 1'b0;
    e_s = 1'b0; e_r = 1'b0; e_busy = 1'b0;
  endtask

  task automatic model_step(input logic s, input logic r);
    logic idle_before, s_go, r_go, all_diff;
    int d;
    raw_h[0][m_k] = s;
    raw_h[1][m_k] = r;
    idle_before = (m_kind == 0) || ((m_k - 1 - m_start) > PW);
    m_conf = 1'b0;
    if (idle_before) begin
      m_kind = 0;
      s_go = m_req[0] | m_pend[0];
      r_go = m_req[1] | m_pend[1];
      if (s_go && r_go) begin
        m_conf = 1'b1; m_kind = 2; m_start = m_k; m_q = 1'b0;
      end else if (s_go) begin
        m_kind = 1; m_start = m_k; m_q = 1'b1;
      end else if (r_go) begin
        m_kind = 2; m_start = m_k; m_q = 1'b0;
      end
      m_pend[0] = 1'b0; m_pend[1] = 1'b0;
    end else begin
      m_pend[0] = m_pend[0] | m_req[0];
      m_pend[1] = m_pend[1] | m_req[1];
    end
    // a level is accepted once the last DB synchronised samples (2 edges old) all disagree
    for (int ch = 0; ch < 2; ch++) begin
      all_diff = 1'b1;
      for (int j = 2; j <= DB + 1; j++)
        if (hist(ch, m_k - j) == m_stable[ch]) all_diff = 1'b0;
      m_req[ch] = 1'b0;
      if (all_diff) begin
        m_stable[ch] = ~m_stable[ch];
        m_req[ch] = m_stable[ch];
      end
    end
    d = m_k - m_start;
    e_s    = (m_kind == 1) && (d < PW);
    e_r    = (m_kind == 2) && (d < PW);
    e_busy = (m_kind != 0) && (d <= PW);
    m_k++;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // one clock: drive inputs, advance the model at the edge, compare on the falling edge
  task automatic cycle(input logic s, input logic r);
    s_in = s;
    r_in = r;
    @(posedge clk);
    if (rst_n) model_step(s, r);
    else model_reset();
    @(negedge clk);
    check("S", s_o, e_s);
    check("R", r_o, e_r);
    check("Busy", busy_o, e_busy);
    check("Conflict", conf_o, m_conf);
    check("Qmodel", q_o, m_q);
    check("S_and_R", s_o & r_o, 1'b0);
  endtask

  typedef struct {
    logic s_in; logic r_in; logic s; logic r; logic busy; logic q;
  } vec_t;
  vec_t tv [16];

  int s_cnt, r_cnt, c_cnt, b_cnt, q1_cnt;
  logic sv, rv;
  int len;

  initial begin
    // S_in held high 12 cycles; vector i applies inputs before edge i, expects outputs after it
    tv[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tv[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tv[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    tv[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; s_in = 1'b0; r_in = 1'b0;
    model_reset();

    // 1: reset held with inputs toggling
    for (int i = 0; i < 3; i++) begin
      cycle(i[0], ~i[0]);
      check("rst_S", s_o, 1'b0);
      check("rst_Qmodel", q_o, 1'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0);

    // 2: table-driven clean set request
    for (int i = 0; i < 16; i++) begin
      cycle(tv[i].s_in, tv[i].r_in);
      check("tv_S", s_o, tv[i].s);
      check("tv_R", r_o, tv[i].r);
      check("tv_Busy", busy_o, tv[i].busy);
      check("tv_Qmodel", q_o, tv[i].q);
    end
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0);

    // 3: a 3-cycle glitch is ignored
    b_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      cycle(i < 3, 1'b0);
      if (busy_o) b_cnt++;
    end
    check("glitch_busy", b_cnt != 0, 1'b0);
    check("glitch_Qmodel", q_o, 1'b1);

    // 4: simultaneous requests, reset wins
    s_cnt = 0; r_cnt = 0; c_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(i < 15, i < 15);
      s_cnt += s_o; r_cnt += r_o; c_cnt += conf_o;
    end
    check("conf_count1", c_cnt == 1, 1'b1);
    check("conf_r2", r_cnt == 2, 1'b1);
    check("conf_s0", s_cnt == 0, 1'b1);
    check("conf_Qmodel", q_o, 1'b0);

    // 5: reset request arrives during a set pulse and is queued
    s_cnt = 0; r_cnt = 0; q1_cnt = 0;
    for (int i = 0; i < 35; i++) begin
      cycle(i < 15, (i >= 1) && (i < 15));
      s_cnt += s_o; r_cnt += r_o; q1_cnt += q_o;
    end
    check("queue_s2", s_cnt == 2, 1'b1);
    check("queue_r2", r_cnt == 2, 1'b1);
    check("queue_q_was1", q1_cnt > 0, 1'b1);
    check("queue_Qmodel", q_o, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0);

    // 6: asynchronous reset during the first set-pulse cycle
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0);
    check("pre_rst_S", s_o, 1'b1);
    #1 rst_n = 1'b0;
    #1 check("async_S", s_o, 1'b0);
    check("async_Qmodel", q_o, 1'b0);
    model_reset();
    s_in = 1'b0;
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b0);
    rst_n = 1'b1;
    s_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      cycle(1'b0, 1'b0);
      s_cnt += s_o;
    end
    check("post_rst_noS", s_cnt == 0, 1'b1);
    check("post_rst_Qmodel", q_o, 1'b0);

    // random bouncy stimulus against the model
    for (int n = 0; n < 120; n++) begin
      sv = $urandom_range(1, 0);
      rv = $urandom_range(1, 0);
      len = $urandom_range(9, 1);
      for (int i = 0; i < len; i++) cycle(sv, rv);
    end
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
